// File: rtl/trakball_emu.sv
// Centipede trackball emulation: PS/2 mouse packets and digital directions feed per-axis
// saturating accumulators that are drained one quadrature count per rate tick.
module trakball_emu #(
  parameter int CLK_HZ      = 12000000,
  parameter int STEP_HZ     = 4000,
  parameter int ACCEL_MAX   = 4,
  parameter int ACCEL_TICKS = 32
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        joy_l,
  input  logic        joy_r,
  input  logic        joy_u,
  input  logic        joy_d,
  input  logic        rot,
  output logic [3:0]  h_count,
  output logic        h_dir,
  output logic [3:0]  v_count,
  output logic        v_dir
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SPW = $clog2(ACCEL_MAX + 1);
  localparam int HLW = $clog2(ACCEL_TICKS + 1);

  function automatic logic signed [11:0] sx9(input logic signed [8:0] v);
    return $signed({{3{v[8]}}, v});
  endfunction

  function automatic logic signed [11:0] sx10(input logic signed [9:0] v);
    return $signed({{2{v[9]}}, v});
  endfunction

  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)
      return 10'sd511;
    else if (v < -12'sd512)
      return -10'sd512;
    else
      return v[9:0];
  endfunction

  // One axis' digital contribution; opposing pair cancels.
  function automatic logic signed [11:0] dig(input logic pos, input logic neg,
                                             input logic signed [11:0] spd);
    if (pos && !neg)
      return spd;
    else if (neg && !pos)
      return -spd;
    else
      return 12'sd0;
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic               tog_q;
  logic               evt;
  logic [SPW-1:0]     speed_q, speed_d;
  logic [HLW-1:0]     hold_q, hold_d;
  logic signed [9:0]  h_acc_q, h_acc_d, v_acc_q, v_acc_d;
  logic [3:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic               h_dir_q, h_dir_d, v_dir_q, v_dir_d;

  logic signed [8:0]  dx9, dy9;
  logic signed [11:0] h_mouse, v_mouse, h_dig, v_dig, h_step, v_step, spd_s;
  logic               any_held;

  assign tick     = (presc_q == PW'(DIV - 1));
  assign presc_d  = tick ? '0 : presc_q + PW'(1);
  assign evt      = ps2_mouse[24] ^ tog_q;
  assign dx9      = $signed({ps2_mouse[4], ps2_mouse[15:8]});
  assign dy9      = $signed({ps2_mouse[5], ps2_mouse[23:16]});
  assign any_held = joy_l | joy_r | joy_u | joy_d;
  assign spd_s    = $signed({{(12-SPW){1'b0}}, speed_q});

  always_comb begin
    h_mouse = 12'sd0;
    v_mouse = 12'sd0;
    h_dig   = 12'sd0;
    v_dig   = 12'sd0;
    h_step  = 12'sd0;
    v_step  = 12'sd0;
    speed_d = speed_q;
    hold_d  = hold_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_dir_d = h_dir_q;
    v_dir_d = v_dir_q;

    if (evt) begin
      if (rot) begin
        h_mouse = sx9(dy9);
        v_mouse = -sx9(dx9);
      end else begin
        h_mouse = sx9(dx9);
        v_mouse = sx9(dy9);
      end
    end

    if (tick) begin
      if (rot) begin
        h_dig = dig(joy_u, joy_d, spd_s);
        v_dig = dig(joy_l, joy_r, spd_s);
      end else begin
        h_dig = dig(joy_r, joy_l, spd_s);
        v_dig = dig(joy_u, joy_d, spd_s);
      end

      // Speed uses its pre-update value for this tick's contribution.
      if (any_held) begin
        if (hold_q == HLW'(ACCEL_TICKS - 1)) begin
          hold_d = '0;
          if (speed_q < SPW'(ACCEL_MAX))
            speed_d = speed_q + SPW'(1);
        end else begin
          hold_d = hold_q + HLW'(1);
        end
      end else begin
        speed_d = SPW'(1);
        hold_d  = '0;
      end

      if (h_acc_q != 10'sd0) begin
        h_dir_d = ~h_acc_q[9];
        h_step  = h_acc_q[9] ? -12'sd1 : 12'sd1;
        h_cnt_d = h_acc_q[9] ? h_cnt_q - 4'd1 : h_cnt_q + 4'd1;
      end
      if (v_acc_q != 10'sd0) begin
        v_dir_d = ~v_acc_q[9];
        v_step  = v_acc_q[9] ? -12'sd1 : 12'sd1;
        v_cnt_d = v_acc_q[9] ? v_cnt_q - 4'd1 : v_cnt_q + 4'd1;
      end
    end

    h_acc_d = sat10(sx10(h_acc_q) + h_mouse + h_dig - h_step);
    v_acc_d = sat10(sx10(v_acc_q) + v_mouse + v_dig - v_step);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc_q <= '0;
      tog_q   <= ps2_mouse[24];
      speed_q <= SPW'(1);
      hold_q  <= '0;
      h_acc_q <= '0;
      v_acc_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_dir_q <= 1'b0;
      v_dir_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tog_q   <= ps2_mouse[24];
      speed_q <= speed_d;
      hold_q  <= hold_d;
      h_acc_q <= h_acc_d;
      v_acc_q <= v_acc_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_dir_q <= h_dir_d;
      v_dir_q <= v_dir_d;
    end
  end

  assign h_count = h_cnt_q;
  assign h_dir   = h_dir_q;
  assign v_count = v_cnt_q;
  assign v_dir   = v_dir_q;

endmodule

// File: tb/tb_trakball_emu.sv
// Directed bench for trakball_emu with a short tick period (4 clocks per step).
module tb_trakball_emu;

  localparam int CLK_HZ  = 40;
  localparam int STEP_HZ = 10;
  localparam int DIV     = CLK_HZ / STEP_HZ;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        joy_l, joy_r, joy_u, joy_d, rot;
  logic [3:0]  h_count, v_count;
  logic        h_dir, v_dir;

  int total = 0;
  int bad   = 0;
  int pm    = 0;
  logic tog;

  trakball_emu #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .ACCEL_MAX(4), .ACCEL_TICKS(32)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse),
    .joy_l(joy_l), .joy_r(joy_r), .joy_u(joy_u), .joy_d(joy_d), .rot(rot),
    .h_count(h_count), .h_dir(h_dir), .v_count(v_count), .v_dir(v_dir)
  );

  always #5 clk_sys = ~clk_sys;

  // Bench copy of the step prescaler phase, used only to place stimulus relative to ticks.
  always @(posedge clk_sys) begin
    if (reset) pm <= 0;
    else       pm <= (pm == DIV - 1) ? 0 : pm + 1;
  end

  typedef struct {
    bit rot;
    int dx;
    int dy;
    int nt;
    int eh;
    bit ehd;
    int ev;
    bit evd;
  } vec_t;

  vec_t tv[10];

  task automatic clk1();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * DIV) clk1();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * DIV && pm != p; i++) clk1();
  endtask

  task automatic send_pkt(input int dx, input int dy);
    logic [8:0] x;
    logic [8:0] y;
    x = dx[8:0];
    y = dy[8:0];
    tog = ~tog;
    ps2_mouse = {tog, y[7:0], x[7:0], 2'b00, y[8], x[8], 4'b0000};
    clk1();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) clk1();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int eh, input int ehd, input int ev, input int evd);
    check({name, ".h_count"}, int'(h_count), eh);
    check({name, ".h_dir"},   int'(h_dir),   ehd);
    check({name, ".v_count"}, int'(v_count), ev);
    check({name, ".v_dir"},   int'(v_dir),   evd);
  endtask

  initial begin
    tv[0] = '{1'b0,    5,    0,   8,  5, 1'b1,  0, 1'b0};
    tv[1] = '{1'b0,   -3,    0,   8,  2, 1'b0,  0, 1'b0};
    tv[2] = '{1'b0,    0,    3,   8,  2, 1'b0,  3, 1'b1};
    tv[3] = '{1'b0,    0,   -5,   8,  2, 1'b0, 14, 1'b0};
    tv[4] = '{1'b1,    2,    0,   8,  2, 1'b0, 12, 1'b0};
    tv[5] = '{1'b1,    0,    3,   8,  5, 1'b1, 12, 1'b0};
    tv[6] = '{1'b0,   20,   -1,  24,  9, 1'b1, 11, 1'b0};
    tv[7] = '{1'b1,   -4,    1,   8, 10, 1'b1, 15, 1'b1};
    tv[8] = '{1'b0,    0,    0,   4, 10, 1'b1, 15, 1'b1};
    tv[9] = '{1'b0, -256,    0, 260, 10, 1'b0, 15, 1'b1};

    tog = 1'b1;
    ps2_mouse = {1'b1, 24'h0};
    {joy_l, joy_r, joy_u, joy_d, rot} = '0;

    // Reset with the toggle bit high must not create an event.
    do_reset();
    check_all("reset", 0, 0, 0, 0);
    run_ticks(10);
    check_all("reset_idle", 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      rot = tv[i].rot;
      send_pkt(tv[i].dx, tv[i].dy);
      run_ticks(tv[i].nt);
      check_all($sformatf("vec%0d", i), tv[i].eh, int'(tv[i].ehd), tv[i].ev, int'(tv[i].evd));
    end
    rot = 1'b0;

    // Latency and a mouse event landing on the tick cycle with acc = 1.
    do_reset();
    wait_phase(0);
    send_pkt(1, 0);
    check("lat_early1", int'(h_count), 0);
    clk1();
    clk1();
    check("lat_early2", int'(h_count), 0);
    send_pkt(1, 0);
    check("simul_step", int'(h_count), 1);
    check("simul_dir", int'(h_dir), 1);
    run_ticks(1);
    check("simul_second", int'(h_count), 2);
    run_ticks(5);
    check("simul_total", int'(h_count), 2);

    // Three +255 packets without a tick in between saturate at 511.
    do_reset();
    wait_phase(0);
    send_pkt(255, 0);
    send_pkt(255, 0);
    send_pkt(255, 0);
    run_ticks(510);
    check("sat_510", int'(h_count), 14);
    run_ticks(1);
    check("sat_511", int'(h_count), 15);
    run_ticks(5);
    check_all("sat_end", 15, 1, 0, 0);

    // Reset mid-motion drops pending counts.
    send_pkt(100, 0);
    run_ticks(10);
    check("mid_pre", int'(h_count), 9);
    reset = 1'b1;
    clk1();
    clk1();
    reset = 1'b0;
    check_all("mid_reset", 0, 0, 0, 0);
    run_ticks(20);
    check_all("mid_after", 0, 0, 0, 0);

    // 200 held ticks deliver 32*1 + 32*2 + 32*3 + 104*4 = 608 counts.
    do_reset();
    joy_r = 1'b1;
    run_ticks(200);
    check_all("accel_hold", 7, 1, 0, 0);
    joy_r = 1'b0;
    run_ticks(408);
    check("accel_607", int'(h_count), 15);
    run_ticks(1);
    check("accel_608", int'(h_count), 0);
    run_ticks(5);
    check_all("accel_end", 0, 1, 0, 0);

    joy_l = 1'b1;
    joy_r = 1'b1;
    run_ticks(50);
    check_all("both_lr", 0, 1, 0, 0);
    joy_l = 1'b0;
    joy_r = 1'b0;
    run_ticks(2);

    rot = 1'b1;
    joy_u = 1'b1;
    run_ticks(3);
    joy_u = 1'b0;
    run_ticks(3);
    check_all("rot_up", 3, 1, 0, 0);
    joy_r = 1'b1;
    run_ticks(2);
    joy_r = 1'b0;
    run_ticks(4);
    check_all("rot_right", 3, 1, 14, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trakball_emu.md
Name: trakball_emu

Overview:
- Synthesises Centipede trackball signals from digital controls: PS/2 mouse packets plus digital left/right/up/down from keyboard or joystick.
- Produces per-axis 4-bit up/down counters and direction bits, paced to a hardware-like step rate.
- Sits between hps_io/input decode and the centipede core's trackball input, replacing the tied-off trackball input.
- Per-axis signed accumulator holds pending motion; a rate tick drains it one count per tick.

Parameters:
- CLK_HZ, 12000000, clk_sys frequency in Hz.
- STEP_HZ, 4000, maximum count steps per second per axis.
- ACCEL_MAX, 4, maximum counts added per tick while a digital direction is held.
- ACCEL_TICKS, 32, ticks a direction must be held before speed increments by 1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_mouse  in  25  [24] toggle strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign.
- joy_l, joy_r, joy_u, joy_d  in  1 each  digital direction, active high.
- rot  in  1  1 = horizontal orientation (axes exchanged).
- h_count  out  4  horizontal up/down counter.
- h_dir  out  1  horizontal direction: 1 = positive (right).
- v_count  out  4  vertical up/down counter.
- v_dir  out  1  vertical direction: 1 = positive (up).

Behaviour:
Reset values:
- h_count = 0, v_count = 0, h_dir = 0, v_dir = 0.
- Accumulators = 0, speed = 1, hold counter = 0, prescaler = 0.
- Mouse toggle shadow loads the current ps2_mouse[24], so reset produces no spurious event.
- Reset asserted mid-motion discards all pending motion.

Tick:
- Prescaler counts 0..CLK_HZ/STEP_HZ-1, then wraps.
- tick is high for one cycle at the wrap.

Mouse event:
- Event = ps2_mouse[24] differs from the shadow; shadow updates the same cycle.
- dx9 = {ps2_mouse[4], ps2_mouse[15:8]} and dy9 = {ps2_mouse[5], ps2_mouse[23:16]}, both 9-bit signed.
- rot = 0: h += dx9, v += dy9.
- rot = 1: h += dy9, v += -dx9.

Digital input (evaluated on tick only):
- Per axis, exactly one of the opposing pair held gives ±speed. With rot = 1, up/down drive h and right/left drive -v.
- Both held, or neither held, contributes 0.
- Speed and hold counter are shared by both axes:
  - Any direction held: hold counter increments each tick; when it reaches ACCEL_TICKS it clears and speed increments, capped at ACCEL_MAX.
  - No direction held: speed = 1 and hold counter = 0 on the next tick.

Accumulator:
- 10-bit signed per axis, saturating at +511/-512. No wrap-around.

Step (on tick, per axis, accumulator nonzero):
- dir <= sign (1 if positive).
- count <= count ±1, modulo 16 (15+1 = 0, 0-1 = 15).
- Accumulator moves one toward zero.
- Accumulator zero: count and dir hold.

Simultaneous events:
- Mouse event, digital contribution and step in the same cycle all apply: acc_next = sat(acc + mouse + digital - step).
- The step decision uses the pre-update accumulator.

Latency:
- First count change no earlier than the next tick after an event, and no later than CLK_HZ/STEP_HZ + 1 cycles after it.
- Outputs are registered.

Test Plan:
- Reset: hold reset 3 cycles with ps2_mouse[24] = 1 -> all outputs 0; no count change over 10 ticks.
- Mouse +5: toggle [24] with dx = +5, rot = 0 -> h_count 0→5 over exactly 5 ticks, h_dir = 1 from the first step, v_count unchanged. Then dx = -3 -> h_count 5→2, h_dir = 0.
- Wrap and saturation: three packets dx = +255 back-to-back, no ticks between -> accumulator saturates at 511; exactly 511 steps follow; h_count ends at 15 ((0+511) mod 16).
- Digital acceleration: hold joy_r for 200 ticks -> speed 1 for ticks 0-31, 2 for ticks 32-63, …, capped at 4 from tick 96; joy_l and joy_r together -> no motion.
- Rotation: rot = 1, mouse dx = +2 -> v_count decrements by 2, v_dir = 0, h untouched. Mouse dy = +3 -> h_count increments by 3.
- Simultaneous: mouse event dx = +1 on the tick cycle with accumulator = 1 -> one step that tick; accumulator = 1 afterwards; total 2 counts delivered.
